// File: rtl/pwm_bank.sv
// Multi-channel PWM with slew-limited duty: each channel takes at most one
// inc/dec step per period, applied only at its own (optionally staggered) period boundary.
module pwm_bank #(
  parameter int CHANNELS   = 2,
  parameter int WIDTH      = 3,
  parameter int PRESCALE   = 1,
  parameter int STAGGER    = 0,
  parameter int INVERT     = 0,
  parameter int RESET_DUTY = 0
) (
  input  logic                      clk_out,
  input  logic                      rst,
  input  logic                      en,
  input  logic [CHANNELS-1:0]       inc,
  input  logic [CHANNELS-1:0]       dec,
  output logic [CHANNELS-1:0]       pwm,
  output logic [CHANNELS*WIDTH-1:0] duty
);

  localparam int PW     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int PERIOD = 1 << WIDTH;
  localparam int OFF    = (STAGGER != 0) ? PERIOD / CHANNELS : 0;

  localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [PW-1:0]    PRE_ONE  = PW'(1);
  localparam logic [WIDTH-1:0] W_ONE    = WIDTH'(1);
  localparam logic [WIDTH-1:0] W_MAX    = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] W_ZERO   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] DUTY_RST = WIDTH'(RESET_DUTY);
  localparam logic             PWM_IDLE = (INVERT != 0);

  typedef enum logic [1:0] {
    PEND_NONE,
    PEND_UP,
    PEND_DOWN
  } pend_e;

  logic [PW-1:0]    presc_q, presc_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             tick;

  assign tick = en && (presc_q == PRE_LAST);

  always_comb begin
    presc_d = presc_q;
    cnt_d   = cnt_q;
    if (en) begin
      if (tick) begin
        presc_d = '0;
        cnt_d   = cnt_q + W_ONE;
      end else begin
        presc_d = presc_q + PRE_ONE;
      end
    end
  end

  always_ff @(posedge clk_out) begin
    if (rst) begin
      presc_q <= '0;
      cnt_q   <= '0;
    end else begin
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
    end
  end

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    localparam logic [WIDTH-1:0] PH_OFF = WIDTH'((gi * OFF) % PERIOD);

    logic [WIDTH-1:0] ph;
    logic [WIDTH-1:0] duty_q, duty_d;
    pend_e            pend_q, pend_d;
    logic             pwm_q, pwm_d;
    logic             boundary, up_req, dn_req;

    assign ph       = cnt_q + PH_OFF;
    assign boundary = tick && (ph == W_MAX);
    assign up_req   = inc[gi] & ~dec[gi];
    assign dn_req   = dec[gi] & ~inc[gi];

    // A strobe seen in the boundary cycle must survive the clear, so it is applied last.
    always_comb begin
      duty_d = duty_q;
      pend_d = pend_q;
      if (boundary) begin
        case (pend_q)
          PEND_UP:   if (duty_q != W_MAX)  duty_d = duty_q + W_ONE;
          PEND_DOWN: if (duty_q != W_ZERO) duty_d = duty_q - W_ONE;
          default:   ;
        endcase
        pend_d = PEND_NONE;
      end
      if (up_req) begin
        pend_d = PEND_UP;
      end else if (dn_req) begin
        pend_d = PEND_DOWN;
      end
      pwm_d = en ? ((ph < duty_q) ^ PWM_IDLE) : PWM_IDLE;
    end

    always_ff @(posedge clk_out) begin
      if (rst) begin
        duty_q <= DUTY_RST;
        pend_q <= PEND_NONE;
        pwm_q  <= PWM_IDLE;
      end else begin
        duty_q <= duty_d;
        pend_q <= pend_d;
        pwm_q  <= pwm_d;
      end
    end

    assign pwm[gi]                  = pwm_q;
    assign duty[gi*WIDTH +: WIDTH]  = duty_q;
  end

endmodule
